// File: rtl/logic16_arbiter_pkg.sv
// Shared definitions for the logic16 arbiter slice.
//   - opcode encodings understood by the shared 16-bit logic unit
//   - response slot state type
package logic16_arbiter_pkg;

    localparam int unsigned OP_W = 2;

    localparam logic [OP_W-1:0] OP_NOT = 2'b00;  // ~a, b ignored
    localparam logic [OP_W-1:0] OP_AND = 2'b01;  // a & b
    localparam logic [OP_W-1:0] OP_OR  = 2'b10;  // a | b
    localparam logic [OP_W-1:0] OP_XOR = 2'b11;  // a ^ b

    typedef enum logic {
        StEmpty,
        StFull
    } state_e;

endpackage

// File: rtl/logic16_arbiter_if.sv
// Bus bundle between the requesters, the arbiter, the shared logic unit and the
// response consumer.
//   req_valid/req_ready   per-requester handshake (N_REQ bits each)
//   req_op/req_a/req_b    flattened per-requester payload
//   lu_op/lu_a/lu_b       operands driven to the shared logic unit
//   lu_out                combinational result from the shared logic unit
//   rsp_*                 single-entry response slot with valid/ready
// Modports: master = requesters/consumer/logic-unit side, slave = arbiter.
interface logic16_arbiter_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned W     = 16,
    parameter int unsigned ID_W  = 2
);
    import logic16_arbiter_pkg::*;

    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ-1:0]      req_ready;
    logic [OP_W*N_REQ-1:0] req_op;
    logic [W*N_REQ-1:0]    req_a;
    logic [W*N_REQ-1:0]    req_b;

    logic [OP_W-1:0]       lu_op;
    logic [W-1:0]          lu_a;
    logic [W-1:0]          lu_b;
    logic [W-1:0]          lu_out;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [W-1:0]          rsp_data;

    modport master (
        output req_valid, req_op, req_a, req_b, lu_out, rsp_ready,
        input  req_ready, lu_op, lu_a, lu_b, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, lu_out, rsp_ready,
        output req_ready, lu_op, lu_a, lu_b, rsp_valid, rsp_id, rsp_data
    );

endinterface

// File: rtl/logic16_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req  in   request vector
//   ptr  in   index of the highest-priority requester this cycle
//   gnt  out  one-hot grant, zero when req is zero
//   idx  out  binary index of the winner; equals ptr when nothing is granted
module logic16_arbiter_rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  idx
);

    logic        found;
    int unsigned j;

    // Walk from ptr upward with wraparound; the first requester seen wins.
    always_comb begin
        gnt   = '0;
        idx   = ptr;
        found = 1'b0;
        j     = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            j = (32'(ptr) + k) % N_REQ;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/logic16_arbiter.sv
// Round-robin arbiter/sequencer sharing one external 16-bit logic unit among
// N_REQ requesters. One operation is accepted per cycle; its result is
// registered into a single-entry response slot tagged with the requester id.
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of logic16_arbiter_if (requests, logic unit, response)
module logic16_arbiter
    import logic16_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned W     = 16,
    parameter int unsigned ID_W  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    logic16_arbiter_if.slave   bus
);

    state_e          state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [W-1:0]    data_q, data_d;
    logic [ID_W-1:0] id_q, id_d;
    // Low from reset until the first clock edge so no grant can appear between
    // reset release and that edge.
    logic            run_q;

    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  idx;
    logic             can_accept;
    logic             handshake;

    logic16_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .req (bus.req_valid),
        .ptr (ptr_q),
        .gnt (gnt),
        .idx (idx)
    );

    // Slot can take a new result when empty, or when it drains this same edge.
    assign can_accept = run_q && ((state_q == StEmpty) || bus.rsp_ready);
    assign handshake  = can_accept && (|gnt);

    assign bus.req_ready = can_accept ? gnt : '0;
    assign bus.rsp_valid = (state_q == StFull);
    assign bus.rsp_id    = id_q;
    assign bus.rsp_data  = data_q;

    // Operand mux; idx falls back to the pointer so the unit never sees X.
    always_comb begin
        bus.lu_op = bus.req_op[OP_W-1:0];
        bus.lu_a  = bus.req_a[W-1:0];
        bus.lu_b  = bus.req_b[W-1:0];
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (idx == ID_W'(i)) begin
                bus.lu_op = bus.req_op[OP_W*i +: OP_W];
                bus.lu_a  = bus.req_a[W*i +: W];
                bus.lu_b  = bus.req_b[W*i +: W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        id_d    = id_q;
        if (handshake) begin
            state_d = StFull;
            data_d  = bus.lu_out;
            id_d    = idx;
            ptr_d   = (32'(idx) == N_REQ - 1) ? '0 : idx + 1'b1;
        end else if ((state_q == StFull) && bus.rsp_ready) begin
            state_d = StEmpty;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            ptr_q   <= '0;
            data_q  <= '0;
            id_q    <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            id_q    <= id_d;
            run_q   <= 1'b1;
        end
    end

endmodule
